// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: one load/store at a time, word-addressed memory,
// byte stores done as read-modify-write, registered load word/offset/select for byte extract.
module mem_access_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Req_Valid,
    output logic              Req_Ready,
    input  logic              Req_Write,
    input  logic              Req_Byte,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       Store_Data,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic              Mem_Rd,
    output logic              Mem_Wr,
    output logic [31:0]       Mem_WData,
    input  logic [31:0]       Mem_RData,
    input  logic              Mem_Ack,
    output logic [31:0]       Load_Memory,
    output logic [1:0]        Offset,
    output logic              Load_Select,
    output logic              Load_Valid,
    output logic              Store_Done,
    output logic              Misaligned
);

    typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        sbyte_q, sbyte_d;
    logic              byte_q, byte_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       ldmem_q, ldmem_d;
    logic [1:0]        off_q, off_d;
    logic              lsel_q, lsel_d;
    logic              lv_q, lv_d;
    logic              sd_q, sd_d;
    logic              mis_q, mis_d;
    logic [31:0]       merged;

    // Byte lane selected by the captured offset takes the store byte; other lanes pass through.
    always_comb begin
        merged = Mem_RData;
        for (int b = 0; b < 4; b++) begin
            if (addr_q[1:0] == 2'(b)) merged[8*b +: 8] = sbyte_q;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sbyte_d = sbyte_q;
        byte_d  = byte_q;
        wdata_d = wdata_q;
        ldmem_d = ldmem_q;
        off_d   = off_q;
        lsel_d  = lsel_q;
        lv_d    = 1'b0;
        sd_d    = 1'b0;
        mis_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (Req_Valid) begin
                    if (!Req_Byte && Addr[1:0] != 2'b00) begin
                        mis_d = 1'b1;
                    end else begin
                        addr_d  = Addr;
                        sbyte_d = Store_Data[7:0];
                        byte_d  = Req_Byte;
                        if (!Req_Write) begin
                            state_d = RD;
                        end else if (Req_Byte) begin
                            state_d = RMW_RD;
                        end else begin
                            wdata_d = Store_Data;
                            state_d = WR;
                        end
                    end
                end
            end
            RD: begin
                if (Mem_Ack) begin
                    ldmem_d = Mem_RData;
                    off_d   = addr_q[1:0];
                    lsel_d  = byte_q;
                    lv_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            RMW_RD: begin
                if (Mem_Ack) begin
                    wdata_d = merged;
                    state_d = RMW_WR;
                end
            end
            WR, RMW_WR: begin
                if (Mem_Ack) begin
                    sd_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            sbyte_q <= '0;
            byte_q  <= 1'b0;
            wdata_q <= '0;
            ldmem_q <= '0;
            off_q   <= '0;
            lsel_q  <= 1'b0;
            lv_q    <= 1'b0;
            sd_q    <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sbyte_q <= sbyte_d;
            byte_q  <= byte_d;
            wdata_q <= wdata_d;
            ldmem_q <= ldmem_d;
            off_q   <= off_d;
            lsel_q  <= lsel_d;
            lv_q    <= lv_d;
            sd_q    <= sd_d;
            mis_q   <= mis_d;
        end
    end

    // Request strobes decode straight from state so a reset edge drops them immediately.
    assign Req_Ready   = (state_q == IDLE);
    assign Mem_Rd      = (state_q == RD) || (state_q == RMW_RD);
    assign Mem_Wr      = (state_q == WR) || (state_q == RMW_WR);
    assign Mem_Addr    = {addr_q[ADDR_W-1:2], 2'b00};
    assign Mem_WData   = wdata_q;
    assign Load_Memory = ldmem_q;
    assign Offset      = off_q;
    assign Load_Select = lsel_q;
    assign Load_Valid  = lv_q;
    assign Store_Done  = sd_q;
    assign Misaligned  = mis_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: loads, byte RMW stores, misalignment, reset abort, back-to-back.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        Req_Valid, Req_Ready, Req_Write, Req_Byte;
    logic [31:0] Addr, Store_Data, Mem_Addr, Mem_WData, Mem_RData, Load_Memory;
    logic        Mem_Rd, Mem_Wr, Mem_Ack;
    logic [1:0]  Offset;
    logic        Load_Select, Load_Valid, Store_Done, Misaligned;

    int checks = 0;
    int errors = 0;
    int overlap = 0;

    mem_access_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Write(Req_Write), .Req_Byte(Req_Byte),
        .Addr(Addr), .Store_Data(Store_Data),
        .Mem_Addr(Mem_Addr), .Mem_Rd(Mem_Rd), .Mem_Wr(Mem_Wr), .Mem_WData(Mem_WData),
        .Mem_RData(Mem_RData), .Mem_Ack(Mem_Ack),
        .Load_Memory(Load_Memory), .Offset(Offset), .Load_Select(Load_Select),
        .Load_Valid(Load_Valid), .Store_Done(Store_Done), .Misaligned(Misaligned)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (Mem_Rd && Mem_Wr) overlap++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic wr, input logic byt, input logic [31:0] a, input logic [31:0] d);
        Req_Valid = 1'b1; Req_Write = wr; Req_Byte = byt; Addr = a; Store_Data = d;
        tick();
        Req_Valid = 1'b0; Addr = 32'hxxxx_xxxx; Store_Data = 32'hxxxx_xxxx;
    endtask

    task automatic test_reset();
        rst = 1'b1; Req_Valid = 1'b0; Req_Write = 1'b0; Req_Byte = 1'b0;
        Addr = '0; Store_Data = '0; Mem_RData = '0; Mem_Ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if ({Req_Ready, Mem_Rd, Mem_Wr, Load_Valid, Store_Done, Misaligned} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 100000",
                     {Req_Ready, Mem_Rd, Mem_Wr, Load_Valid, Store_Done, Misaligned});
        end
        checks++;
        if ({Mem_Addr, Mem_WData, Load_Memory, Offset, Load_Select} !== 99'd0) begin
            errors++;
            $display("FAIL reset_data got %h/%h/%h/%0d/%b want zeros",
                     Mem_Addr, Mem_WData, Load_Memory, Offset, Load_Select);
        end
    endtask

    task automatic test_word_load();
        req(1'b0, 1'b0, 32'h100, 32'h0);
        checks++;
        if (!(Mem_Rd === 1'b1 && Mem_Wr === 1'b0 && Mem_Addr === 32'h100 && Req_Ready === 1'b0)) begin
            errors++;
            $display("FAIL wl_req rd=%b wr=%b addr=%h rdy=%b want 1 0 100 0", Mem_Rd, Mem_Wr, Mem_Addr, Req_Ready);
        end
        Mem_Ack = 1'b1; Mem_RData = 32'hDEADBEEF;
        tick();
        Mem_Ack = 1'b0; Mem_RData = '0;
        checks++;
        if (!(Load_Valid === 1'b1 && Load_Memory === 32'hDEADBEEF && Offset === 2'd0 &&
              Load_Select === 1'b0 && Mem_Rd === 1'b0 && Req_Ready === 1'b1)) begin
            errors++;
            $display("FAIL wl_result lv=%b lm=%h off=%0d sel=%b rd=%b rdy=%b want 1 deadbeef 0 0 0 1",
                     Load_Valid, Load_Memory, Offset, Load_Select, Mem_Rd, Req_Ready);
        end
        tick();
        checks++;
        if (Load_Valid !== 1'b0) begin
            errors++;
            $display("FAIL wl_pulse Load_Valid=%b want 0", Load_Valid);
        end
    endtask

    task automatic test_byte_load();
        int rd_cycles = 0;
        int bad = 0;
        req(1'b0, 1'b1, 32'h102, 32'h0);
        for (int i = 0; i < 4; i++) begin
            if (Mem_Rd === 1'b1) rd_cycles++;
            if (Mem_Addr !== 32'h100 || Req_Ready !== 1'b0) bad++;
            if (i == 3) begin Mem_Ack = 1'b1; Mem_RData = 32'h11223344; end
            tick();
        end
        Mem_Ack = 1'b0; Mem_RData = '0;
        checks++;
        if (rd_cycles != 4 || bad != 0 || Mem_Rd !== 1'b0) begin
            errors++;
            $display("FAIL bl_wait rd_cycles=%0d bad=%0d rd_after=%b want 4 0 0", rd_cycles, bad, Mem_Rd);
        end
        checks++;
        if (!(Load_Valid === 1'b1 && Load_Memory === 32'h11223344 && Offset === 2'd2 && Load_Select === 1'b1)) begin
            errors++;
            $display("FAIL bl_result lv=%b lm=%h off=%0d sel=%b want 1 11223344 2 1",
                     Load_Valid, Load_Memory, Offset, Load_Select);
        end
        tick();
    endtask

    task automatic test_byte_store(input logic [31:0] a, input logic [31:0] d,
                                   input logic [31:0] mem, input logic [31:0] exp_w);
        req(1'b1, 1'b1, a, d);
        checks++;
        if (!(Mem_Rd === 1'b1 && Mem_Wr === 1'b0 && Mem_Addr === {a[31:2], 2'b00})) begin
            errors++;
            $display("FAIL bs_read a=%h rd=%b wr=%b addr=%h", a, Mem_Rd, Mem_Wr, Mem_Addr);
        end
        Mem_Ack = 1'b1; Mem_RData = mem;
        tick();
        Mem_RData = '0;
        checks++;
        if (!(Mem_Wr === 1'b1 && Mem_Rd === 1'b0 && Mem_WData === exp_w && Mem_Addr === {a[31:2], 2'b00})) begin
            errors++;
            $display("FAIL bs_write a=%h wr=%b rd=%b wdata=%h want %h", a, Mem_Wr, Mem_Rd, Mem_WData, exp_w);
        end
        tick();
        Mem_Ack = 1'b0;
        checks++;
        if (!(Store_Done === 1'b1 && Mem_Wr === 1'b0 && Load_Valid === 1'b0 &&
              Load_Memory === 32'h11223344 && Offset === 2'd2 && Load_Select === 1'b1)) begin
            errors++;
            $display("FAIL bs_done a=%h sd=%b wr=%b lv=%b lm=%h off=%0d sel=%b",
                     a, Store_Done, Mem_Wr, Load_Valid, Load_Memory, Offset, Load_Select);
        end
        tick();
        checks++;
        if (Store_Done !== 1'b0) begin
            errors++;
            $display("FAIL bs_pulse Store_Done=%b want 0", Store_Done);
        end
    endtask

    task automatic test_misaligned();
        req(1'b0, 1'b0, 32'h103, 32'h0);
        checks++;
        if (!(Misaligned === 1'b1 && Mem_Rd === 1'b0 && Mem_Wr === 1'b0 && Req_Ready === 1'b1)) begin
            errors++;
            $display("FAIL mis_pulse mis=%b rd=%b wr=%b rdy=%b want 1 0 0 1", Misaligned, Mem_Rd, Mem_Wr, Req_Ready);
        end
        tick();
        checks++;
        if (!(Misaligned === 1'b0 && Mem_Rd === 1'b0 && Load_Memory === 32'h11223344)) begin
            errors++;
            $display("FAIL mis_after mis=%b rd=%b lm=%h want 0 0 11223344", Misaligned, Mem_Rd, Load_Memory);
        end
    endtask

    task automatic test_reset_abort();
        req(1'b0, 1'b0, 32'h300, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0; Mem_Ack = 1'b1; Mem_RData = 32'hFFFFFFFF;
        checks++;
        if (!(Mem_Rd === 1'b0 && Req_Ready === 1'b1 && Load_Memory === 32'h0 && Offset === 2'd0 && Load_Select === 1'b0)) begin
            errors++;
            $display("FAIL rst_abort rd=%b rdy=%b lm=%h off=%0d sel=%b want 0 1 0 0 0",
                     Mem_Rd, Req_Ready, Load_Memory, Offset, Load_Select);
        end
        tick();
        Mem_Ack = 1'b0; Mem_RData = '0;
        checks++;
        if (!(Load_Valid === 1'b0 && Load_Memory === 32'h0 && Mem_Rd === 1'b0)) begin
            errors++;
            $display("FAIL rst_stray_ack lv=%b lm=%h rd=%b want 0 0 0", Load_Valid, Load_Memory, Mem_Rd);
        end
        req(1'b0, 1'b0, 32'h104, 32'h0);
        tick();
        Mem_Ack = 1'b1; Mem_RData = 32'h0BADF00D;
        tick();
        Mem_Ack = 1'b0; Mem_RData = '0;
        checks++;
        if (!(Load_Valid === 1'b1 && Load_Memory === 32'h0BADF00D && Offset === 2'd0)) begin
            errors++;
            $display("FAIL rst_recover lv=%b lm=%h off=%0d want 1 0badf00d 0", Load_Valid, Load_Memory, Offset);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        overlap = 0;
        req(1'b1, 1'b0, 32'h400, 32'h12345678);
        Req_Valid = 1'b1; Req_Write = 1'b0; Req_Byte = 1'b0; Addr = 32'h400;
        checks++;
        if (!(Mem_Wr === 1'b1 && Mem_WData === 32'h12345678 && Mem_Addr === 32'h400 && Req_Ready === 1'b0)) begin
            errors++;
            $display("FAIL b2b_write wr=%b wdata=%h addr=%h rdy=%b", Mem_Wr, Mem_WData, Mem_Addr, Req_Ready);
        end
        Mem_Ack = 1'b1;
        tick();
        Mem_Ack = 1'b0;
        checks++;
        if (!(Store_Done === 1'b1 && Req_Ready === 1'b1 && Mem_Wr === 1'b0 && Mem_Rd === 1'b0)) begin
            errors++;
            $display("FAIL b2b_done sd=%b rdy=%b wr=%b rd=%b want 1 1 0 0", Store_Done, Req_Ready, Mem_Wr, Mem_Rd);
        end
        tick();
        Req_Valid = 1'b0;
        checks++;
        if (!(Mem_Rd === 1'b1 && Mem_Wr === 1'b0 && Mem_Addr === 32'h400 && Store_Done === 1'b0)) begin
            errors++;
            $display("FAIL b2b_read rd=%b wr=%b addr=%h sd=%b want 1 0 400 0", Mem_Rd, Mem_Wr, Mem_Addr, Store_Done);
        end
        Mem_Ack = 1'b1; Mem_RData = 32'h12345678;
        tick();
        Mem_Ack = 1'b0; Mem_RData = '0;
        checks++;
        if (!(Load_Valid === 1'b1 && Load_Memory === 32'h12345678 && overlap == 0)) begin
            errors++;
            $display("FAIL b2b_load lv=%b lm=%h overlap=%0d want 1 12345678 0", Load_Valid, Load_Memory, overlap);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_load();
        test_byte_store(32'h201, 32'h000000AB, 32'hCAFEF00D, 32'hCAFEAB0D);
        test_byte_store(32'h203, 32'hFFFFFF5A, 32'h00000000, 32'h5A000000);
        test_byte_store(32'h200, 32'h00000077, 32'hAABBCCDD, 32'hAABBCC77);
        test_misaligned();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Data-memory access controller in the MEM stage. It sits directly upstream of the load byte-extract stage.
- Accepts one load/store request at a time from the pipeline over a valid/ready handshake and drives a word-addressed data memory with a request/ack interface.
- For loads it registers the fetched word, byte offset and byte/word select, which feed the load byte-extract stage.
- Byte stores are done as read-modify-write, because the memory only writes full words.

Parameters:
- ADDR_W, 32, byte-address width of Addr and Mem_Addr.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Req_Valid  in  1  pipeline request valid.
- Req_Ready  out  1  controller can accept a request; high only in IDLE.
- Req_Write  in  1  1 = store, 0 = load.
- Req_Byte  in  1  1 = byte access, 0 = word access.
- Addr  in  ADDR_W  byte address.
- Store_Data  in  32  store data; byte stores use [7:0].
- Mem_Addr  out  ADDR_W  word-aligned address, {Addr[ADDR_W-1:2],2'b00}.
- Mem_Rd  out  1  memory read request; held until Mem_Ack.
- Mem_Wr  out  1  memory write request; held until Mem_Ack.
- Mem_WData  out  32  write word.
- Mem_RData  in  32  read word; valid when Mem_Ack=1 during a read.
- Mem_Ack  in  1  memory completion, one cycle.
- Load_Memory  out  32  registered read word, passed to the byte-extract stage.
- Offset  out  2  registered Addr[1:0] of the last load.
- Load_Select  out  1  registered Req_Byte of the last load.
- Load_Valid  out  1  one-cycle pulse: Load_Memory/Offset/Load_Select are new.
- Store_Done  out  1  one-cycle pulse: store committed.
- Misaligned  out  1  one-cycle pulse: word access with Addr[1:0]!=0 was rejected.

Behaviour:
- Reset: state=IDLE; all outputs 0 except Req_Ready=1. Reset mid-operation aborts the transaction: Mem_Rd/Mem_Wr drop at that edge and no Load_Valid/Store_Done is issued.
- States: IDLE, RD, WR, RMW_RD, RMW_WR.
- Acceptance: a request is accepted on an edge where Req_Valid & Req_Ready. Addr, Store_Data, Req_Write and Req_Byte are captured at that edge; inputs are don't-care afterwards.
- IDLE transition on accept:
  - word access with Addr[1:0]!=0: Misaligned=1 for the next cycle, stay IDLE, no memory request.
  - load: go to RD.
  - word store: go to WR.
  - byte store: go to RMW_RD.
- RD / RMW_RD: Mem_Rd=1 and Mem_Addr stable from the first cycle until the Mem_Ack cycle inclusive. Ack may arrive in the first cycle (zero wait).
- RD with Mem_Ack: at that edge Load_Memory<=Mem_RData, Offset<=captured Addr[1:0], Load_Select<=captured Req_Byte, then go to IDLE. Load_Valid=1 for exactly the next cycle.
- RMW_RD with Mem_Ack: Mem_WData<=Mem_RData with byte lane Offset (bits 8*Offset+7 : 8*Offset) replaced by Store_Data[7:0]; other lanes unchanged. Go to RMW_WR.
- WR / RMW_WR: Mem_Wr=1, Mem_WData stable (WR uses the captured Store_Data) until Mem_Ack. On ack go to IDLE; Store_Done=1 for the next cycle.
- Mem_Rd and Mem_Wr are never high together. Mem_Ack outside RD/WR/RMW_* is ignored.
- Load_Memory/Offset/Load_Select hold their values until the next load ack. Stores and misaligned requests do not modify them.
- Req_Ready=1 in the same cycle as the Load_Valid/Store_Done/Misaligned pulse, so back-to-back requests are accepted.
- Latency, zero-wait memory:
  - load: accept edge N, Mem_Rd in cycle N+1, Load_Valid in cycle N+2.
  - byte store: Store_Done in cycle N+3.

Test Plan:
- Word load Addr=0x100, Mem_RData=0xDEADBEEF, ack in first cycle -> Mem_Addr=0x100, Load_Valid one cycle after ack, Load_Memory=0xDEADBEEF, Offset=0, Load_Select=0.
- Byte load Addr=0x102, memory word 0x11223344, 3 wait cycles -> Mem_Rd held 4 cycles, Mem_Addr=0x100, Load_Memory=0x11223344, Offset=2, Load_Select=1; Req_Ready=0 throughout.
- Byte store Addr=0x201, Store_Data=0x000000AB, memory word 0xCAFEF00D -> read of 0x200, then write Mem_WData=0xCAFEAB0D, Store_Done one pulse, Load_* unchanged.
- Word load Addr=0x103 -> Misaligned pulse, no Mem_Rd/Mem_Wr, Req_Ready stays 1.
- rst asserted in RD before ack, then Mem_Ack arrives -> Mem_Rd=0 after the reset edge, no Load_Valid, outputs at reset values, next request processed normally.
- Word store 0x12345678 then immediate load of the same address, Req_Valid held high -> second request accepted in the Store_Done cycle, Mem_Wr and Mem_Rd never overlap.
